// File: rtl/i2c_multi_digit_segment_controller_if.sv
// i2c_multi_digit_segment_controller_if: I2C pad bundle (scl_in/sda_in from pads, sda_oe = pull SDA low)
interface i2c_multi_digit_segment_controller_if;
  logic scl_in;
  logic sda_in;
  logic sda_oe;
  modport master (output scl_in, sda_in, input sda_oe);
  modport slave (input scl_in, sda_in, output sda_oe);
endinterface

// File: rtl/i2c_multi_digit_segment_controller.sv
// i2c_multi_digit_segment_controller: I2C target for a multiplexed 7-segment display (ports: clk, rst_n, bus{scl_in,sda_in,sda_oe}, seg_out, digit_en, busy)
module i2c_multi_digit_segment_controller #(
  parameter int NUM_DIGITS = 4,
  parameter logic [6:0] I2C_ADDR = 7'h3A,
  parameter int SCAN_DIV = 1024,
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  i2c_multi_digit_segment_controller_if.slave bus,
  output logic [7:0] seg_out,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic busy
);
  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int PL = SCAN_DIV / 16;
  localparam int SW = PL > 1 ? $clog2(PL) : 1;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int AW = $clog2(NUM_DIGITS + 1);
  localparam logic [7:0] CTRL = 8'(NUM_DIGITS);
  localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, WAIT_STOP} state_t;
  state_t state, state_n;
  logic [1:0] s1, s2, filt, fd;
  logic [FW-1:0] fc [2];
  logic [2:0] bit_cnt, bit_n;
  logic [7:0] sh, sh_n, ptr, ptr_n, ptr_inc, rdata;
  logic oe, oe_n, ack, ack_n, rw, rw_n, nack, nack_n, busy_n, we;
  logic [7:0] regs [NUM_DIGITS+1];
  logic [SW-1:0] sub;
  logic [3:0] phase;
  logic [IW-1:0] idx;
  logic [7:0] dig;
  logic on;
  // Bit 0 is SCL, bit 1 is SDA; lines idle high so filters reset to 1 to avoid a phantom edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= '1;
      s2 <= '1;
      filt <= '1;
      fd <= '1;
      fc <= '{default: '0};
    end else begin
      s1 <= {bus.sda_in, bus.scl_in};
      s2 <= s1;
      fd <= filt;
      for (int i = 0; i < 2; i++)
        if (s2[i] == filt[i]) fc[i] <= '0;
        else if (fc[i] == FW'(FILT_LEN - 1)) begin
          filt[i] <= s2[i];
          fc[i] <= '0;
        end else fc[i] <= fc[i] + 1'b1;
    end
  wire scl_rise = filt[0] & ~fd[0];
  wire scl_fall = ~filt[0] & fd[0];
  wire start = fd[1] & ~filt[1] & filt[0] & fd[0];
  wire stop = ~fd[1] & filt[1] & filt[0] & fd[0];
  wire sda = filt[1];
  assign ptr_inc = ptr == CTRL ? 8'h00 : ptr + 8'd1;
  assign rdata = ptr <= CTRL ? regs[ptr[AW-1:0]] : 8'h00;
  assign bus.sda_oe = oe;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      bit_cnt <= '0;
      sh <= '0;
      ptr <= '0;
      oe <= 1'b0;
      ack <= 1'b0;
      rw <= 1'b0;
      nack <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      bit_cnt <= bit_n;
      sh <= sh_n;
      ptr <= ptr_n;
      oe <= oe_n;
      ack <= ack_n;
      rw <= rw_n;
      nack <= nack_n;
      busy <= busy_n;
    end
  // ack marks that the SCL rise of the 9th bit has passed, so the next fall ends the acknowledge slot
  always_comb begin
    state_n = state;
    bit_n = bit_cnt;
    sh_n = sh;
    ptr_n = ptr;
    oe_n = oe;
    ack_n = ack;
    rw_n = rw;
    nack_n = nack;
    busy_n = busy;
    we = 1'b0;
    if (stop) begin
      state_n = IDLE;
      oe_n = 1'b0;
      busy_n = 1'b0;
    end else if (start) begin
      state_n = ADDR;
      bit_n = '0;
      oe_n = 1'b0;
    end else
      case (state)
        ADDR, PTR, WR:
          if (scl_rise) begin
            sh_n = {sh[6:0], sda};
            bit_n = bit_cnt + 1'b1;
            ack_n = 1'b0;
            if (bit_cnt == 3'd7)
              case (state)
                ADDR: begin
                  state_n = sh_n[7:1] == I2C_ADDR ? ADDR_ACK : WAIT_STOP;
                  busy_n = busy | (sh_n[7:1] == I2C_ADDR);
                  rw_n = sda;
                end
                PTR: begin
                  state_n = PTR_ACK;
                  ptr_n = sh_n;
                end
                default: state_n = WR_ACK;
              endcase
          end
        ADDR_ACK, PTR_ACK, WR_ACK:
          if (scl_rise) ack_n = 1'b1;
          else if (scl_fall && !ack) begin
            oe_n = 1'b1;
            we = state == WR_ACK;
            ptr_n = state == WR_ACK ? ptr_inc : ptr;
          end else if (scl_fall) begin
            bit_n = '0;
            state_n = state != ADDR_ACK ? WR : rw ? RD : PTR;
            sh_n = state == ADDR_ACK && rw ? rdata : sh;
            oe_n = state == ADDR_ACK && rw && !rdata[7];
          end
        RD:
          if (scl_rise) begin
            bit_n = bit_cnt + 1'b1;
            ack_n = 1'b0;
            state_n = bit_cnt == 3'd7 ? RD_ACK : RD;
          end else if (scl_fall) begin
            sh_n = {sh[6:0], 1'b0};
            oe_n = ~sh[6];
          end
        RD_ACK:
          if (scl_rise) begin
            ack_n = 1'b1;
            nack_n = sda;
            ptr_n = sda ? ptr : ptr_inc;
          end else if (scl_fall && !ack) oe_n = 1'b0;
          else if (scl_fall) begin
            bit_n = '0;
            state_n = nack ? WAIT_STOP : RD;
            sh_n = nack ? sh : rdata;
            oe_n = !nack && !rdata[7];
          end
        default: ;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) regs <= '{default: '0};
    else if (we && ptr <= CTRL) regs[ptr[AW-1:0]] <= sh;
  // A digit slot is 16 phases of PL cycles; phase is compared with brightness for the PWM duty
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sub <= '0;
      phase <= '0;
      idx <= '0;
    end else if (sub == SW'(PL - 1)) begin
      sub <= '0;
      phase <= phase + 4'd1;
      if (phase == 4'hF) idx <= idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
    end else sub <= sub + 1'b1;
  assign dig = regs[AW'(idx)];
  assign on = regs[AW'(NUM_DIGITS)][0] && phase <= regs[AW'(NUM_DIGITS)][7:4];
  assign seg_out = !on ? 8'h00 : regs[AW'(NUM_DIGITS)][1] ? {dig[7], HEX[dig[3:0]]} : dig;
  assign digit_en = on ? NUM_DIGITS'(1) << idx : '0;
endmodule
